// File: rtl/text_buffer_if.sv
// text_buffer_if: writer/reader bus of the VGA text tile store.
// master = CPU/UART writer plus pixel pipeline, slave = text_buffer.
interface text_buffer_if #(
  parameter int ADDR_COL_WIDTH = 7,
  parameter int ADDR_ROW_WIDTH = 5,
  parameter int DATA_WIDTH     = 15
);
  logic                      wr_en_i;
  logic [ADDR_COL_WIDTH-1:0] col_w_i;
  logic [ADDR_ROW_WIDTH-1:0] row_w_i;
  logic [DATA_WIDTH-1:0]     din_i;
  logic [ADDR_COL_WIDTH-1:0] col_r_i;
  logic [ADDR_ROW_WIDTH-1:0] row_r_i;
  logic [DATA_WIDTH-1:0]     dout_o;
  logic                      scroll_i;
  logic                      clear_i;
  logic [DATA_WIDTH-1:0]     fill_i;
  logic                      busy_o;
  logic [ADDR_COL_WIDTH-1:0] cursor_col_i;
  logic [ADDR_ROW_WIDTH-1:0] cursor_row_i;
  logic                      cursor_o;

  modport master (
    output wr_en_i, col_w_i, row_w_i, din_i,
    output col_r_i, row_r_i,
    output scroll_i, clear_i, fill_i,
    output cursor_col_i, cursor_row_i,
    input  dout_o, busy_o, cursor_o
  );

  modport slave (
    input  wr_en_i, col_w_i, row_w_i, din_i,
    input  col_r_i, row_r_i,
    input  scroll_i, clear_i, fill_i,
    input  cursor_col_i, cursor_row_i,
    output dout_o, busy_o, cursor_o
  );
endinterface

// File: rtl/text_buffer.sv
// text_buffer: 80x30 {attr,char} tile store with circular-row scroll and clear engine.
// Optional blinking cursor flag enabled by defining TEXT_BUFFER_CURSOR_EN.
module text_buffer #(
  parameter int H_TILES        = 80,
  parameter int V_TILES        = 30,
  parameter int ADDR_COL_WIDTH = 7,
  parameter int ADDR_ROW_WIDTH = 5,
  parameter int CHAR_WIDTH     = 7,
  parameter int ATTR_WIDTH     = 8,
  parameter int DATA_WIDTH     = ATTR_WIDTH + CHAR_WIDTH,
  parameter int BLINK_BITS     = 24
) (
  input logic         clk_i,
  input logic         rst_i,
  text_buffer_if.slave bus
);

  localparam int NUM_TILES = H_TILES * V_TILES;
  localparam int IDX_W     = $clog2(NUM_TILES);
  localparam int CW        = ADDR_COL_WIDTH;
  localparam int RW        = ADDR_ROW_WIDTH;

  localparam logic [CW-1:0]    COL_MAX   = CW'(H_TILES - 1);
  localparam logic [RW-1:0]    ROW_MAX   = RW'(V_TILES - 1);
  localparam logic [RW:0]      ROW_LIM   = (RW + 1)'(V_TILES);
  localparam logic [IDX_W-1:0] LAST_TILE = IDX_W'(NUM_TILES - 1);
  localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(H_TILES - 1);
  localparam logic [IDX_W-1:0] ROW_SPAN  = IDX_W'(H_TILES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem [NUM_TILES];

  state_t                state_q, state_d;
  logic [RW-1:0]         top_q, top_d;
  logic [RW-1:0]         row_q, row_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] dout_q;

  logic                  busy;
  logic [IDX_W-1:0]      clr_idx;
  logic                  w_ok, r_ok;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Logical (col,row) to physical tile index through the circular row base.
  function automatic logic [IDX_W-1:0] tile_idx(
    input logic [CW-1:0] col,
    input logic [RW-1:0] row,
    input logic [RW-1:0] top
  );
    logic [RW:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= ROW_LIM) sum = sum - ROW_LIM;
    return IDX_W'(sum) * ROW_SPAN + IDX_W'(col);
  endfunction

  assign busy  = (state_q != IDLE);
  assign w_ok  = (bus.col_w_i <= COL_MAX) && (bus.row_w_i <= ROW_MAX);
  assign r_ok  = (bus.col_r_i <= COL_MAX) && (bus.row_r_i <= ROW_MAX);
  assign w_idx = tile_idx(bus.col_w_i, bus.row_w_i, top_q);
  assign r_idx = tile_idx(bus.col_r_i, bus.row_r_i, top_q);

  // Clear engine state, scroll base, counters and latched fill value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      top_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // Accept clear/scroll when idle (clear wins), then sweep the fill value.
  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    clr_idx = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clear_i) begin
          state_d = CLR_ALL;
          top_d   = '0;
          cnt_d   = '0;
          fill_d  = bus.fill_i;
        end else if (bus.scroll_i) begin
          state_d = CLR_ROW;
          row_d   = top_q;
          top_d   = (top_q == ROW_MAX) ? '0 : top_q + 1'b1;
          cnt_d   = '0;
          fill_d  = bus.fill_i;
        end
      end
      CLR_ALL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_TILE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      CLR_ROW: begin
        clr_idx = IDX_W'(row_q) * ROW_SPAN + cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_COL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single write port: the clear engine owns it while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = w_idx;
    mem_wdata = bus.din_i;
    if (busy) begin
      mem_we    = 1'b1;
      mem_widx  = clr_idx;
      mem_wdata = fill_q;
    end else if (bus.wr_en_i && w_ok) begin
      mem_we = 1'b1;
    end
  end

  // Tile RAM write.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Registered read; same-cycle write is not forwarded, out of range reads 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) dout_q <= '0;
    else       dout_q <= r_ok ? mem[r_idx] : '0;
  end

  assign bus.dout_o = dout_q;
  assign bus.busy_o = busy;

`ifdef TEXT_BUFFER_CURSOR_EN
  logic [BLINK_BITS-1:0] blink_q;
  logic                  cursor_q;

  // Free-running blink counter and cursor flag aligned with dout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blink_q  <= '0;
      cursor_q <= 1'b0;
    end else begin
      blink_q  <= blink_q + 1'b1;
      cursor_q <= (bus.col_r_i == bus.cursor_col_i) &&
                  (bus.row_r_i == bus.cursor_row_i) &&
                  blink_q[BLINK_BITS-1];
    end
  end

  assign bus.cursor_o = cursor_q;
`else
  logic unused_cursor;
  assign unused_cursor = ^{bus.cursor_col_i, bus.cursor_row_i, BLINK_BITS[0]};
  assign bus.cursor_o  = 1'b0;
`endif

endmodule
